// File: rtl/cdc_bus_tx_ctrl_if.sv
// Bundle between the source-domain requesters, the transmit controller and
// the destination synchronizer.
//
// Handshake: a requester raises reqN_valid with reqN_data and holds both
// until it sees reqN_ready high on a rising CLK edge; that edge transfers the
// word. reqN_ready is combinational and only ever high in the cycle the
// controller accepts the word. A valid that drops before ready is simply
// ignored. Async_bus/bus_EN form a level-enable bus: the bus is stable for
// the whole time bus_EN is high and for the gap after it.
interface cdc_bus_tx_ctrl_if #(
    parameter int Width = 8
);
    logic             req0_valid;
    logic [Width-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [Width-1:0] req1_data;
    logic             req1_ready;
    logic [Width-1:0] Async_bus;
    logic             bus_EN;
    logic             busy;
    logic             grant_id;
    logic [1:0]       state_dbg;

    // Controller side: takes requests, drives the synchronizer bus.
    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, Async_bus, bus_EN, busy, grant_id,
        state_dbg
    );

    // Requester / observer side.
    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, Async_bus, bus_EN, busy, grant_id,
        state_dbg
    );
endinterface

// File: rtl/cdc_bus_tx_ctrl.sv
// Source-domain transmit controller for a level-enable data synchronizer.
// Two requesters are arbitrated round-robin; each accepted word is placed on
// Async_bus and announced by holding bus_EN high for HIGH_CYCLES cycles,
// followed by at least LOW_CYCLES GAP cycles plus the next IDLE accept cycle
// with bus_EN low, so the destination sees exactly one rising edge per word.
module cdc_bus_tx_ctrl #(
    parameter int Width       = 8,
    parameter int HIGH_CYCLES = 3,
    parameter int LOW_CYCLES  = 3
) (
    input logic              CLK,
    input logic              Reset,
    cdc_bus_tx_ctrl_if.master io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] HighInit = 4'(HIGH_CYCLES - 1);
    localparam logic [3:0] LowInit  = 4'(LOW_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [Width-1:0] bus_q, bus_d;
    logic             en_q, en_d;
    logic             gid_q, gid_d;

    logic             any_valid;
    logic             sel;
    logic [Width-1:0] sel_data;

    // Round-robin choice: a lone requester wins; on a tie the one that did
    // not win last time goes first.
    always_comb begin
        any_valid = io.req0_valid | io.req1_valid;
        if (io.req0_valid && io.req1_valid) begin
            sel = ~last_q;
        end else begin
            sel = io.req1_valid;
        end
        sel_data = sel ? io.req1_data : io.req0_data;
    end

    // Next-state and handshake logic; ready only exists in IDLE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        bus_d         = bus_q;
        en_d          = en_q;
        gid_d         = gid_q;
        io.req0_ready = 1'b0;
        io.req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    io.req0_ready = ~sel;
                    io.req1_ready = sel;
                    bus_d         = sel_data;
                    en_d          = 1'b1;
                    gid_d         = sel;
                    last_d        = sel;
                    cnt_d         = HighInit;
                    state_d       = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    en_d    = 1'b0;
                    cnt_d   = LowInit;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops bus_EN without a clock.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            bus_q   <= '0;
            en_q    <= 1'b0;
            gid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            gid_q   <= gid_d;
        end
    end

    assign io.Async_bus = bus_q;
    assign io.bus_EN    = en_q;
    assign io.grant_id  = gid_q;
    assign io.busy      = (state_q != IDLE);
    assign io.state_dbg = state_q;

endmodule

// File: tb/tb_cdc_bus_tx_ctrl.sv
// Bench for cdc_bus_tx_ctrl: lane 0 uses default timing, lane 1 the minimum
// HIGH_CYCLES=LOW_CYCLES=1. A timing-level reference model predicts each
// grant, the cycle its bus_EN rises, ready and busy; a monitor pops and
// compares on every bus_EN rising edge; a 2-stage destination model in a
// separate clock domain checks one captured word per pulse.
`timescale 1ns/1ps
module tb_cdc_bus_tx_ctrl;
  localparam int W  = 8;
  localparam int EW = 16 + 1 + W;

  logic CLK  = 1'b0;
  logic DCLK = 1'b0;
  logic rst_n [2];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic         v0 [2];
  logic         v1 [2];
  logic [W-1:0] d0 [2];
  logic [W-1:0] d1 [2];
  logic         r0 [2];
  logic         r1 [2];
  logic         en [2];
  logic [W-1:0] abus [2];
  logic         busy [2];
  logic         gid [2];

  logic [W-1:0]  src0_q [2][$];
  logic [W-1:0]  src1_q [2][$];
  logic [EW-1:0] exp_q [2][$];
  logic [W-1:0]  dst_q [2][$];
  int m_free [2];
  int m_acc [2];
  int pulses [2];
  int dpulses [2];
  int dlost [2];

  // clock / reset block
  always #5 CLK = ~CLK;
  always #3.5 DCLK = ~DCLK;
  always @(posedge CLK) cyc <= cyc + 1;

  cdc_bus_tx_ctrl_if #(.Width(W)) bif0 ();
  cdc_bus_tx_ctrl_if #(.Width(W)) bif1 ();

  cdc_bus_tx_ctrl #(.Width(W), .HIGH_CYCLES(3), .LOW_CYCLES(3)) u_dut (
    .CLK(CLK), .Reset(rst_n[0]), .io(bif0)
  );
  cdc_bus_tx_ctrl #(.Width(W), .HIGH_CYCLES(1), .LOW_CYCLES(1)) u_dut_min (
    .CLK(CLK), .Reset(rst_n[1]), .io(bif1)
  );

  assign bif0.req0_valid = v0[0];
  assign bif0.req0_data  = d0[0];
  assign bif0.req1_valid = v1[0];
  assign bif0.req1_data  = d1[0];
  assign bif1.req0_valid = v0[1];
  assign bif1.req0_data  = d0[1];
  assign bif1.req1_valid = v1[1];
  assign bif1.req1_data  = d1[1];
  assign r0[0]   = bif0.req0_ready;
  assign r1[0]   = bif0.req1_ready;
  assign en[0]   = bif0.bus_EN;
  assign abus[0] = bif0.Async_bus;
  assign busy[0] = bif0.busy;
  assign gid[0]  = bif0.grant_id;
  assign r0[1]   = bif1.req0_ready;
  assign r1[1]   = bif1.req1_ready;
  assign en[1]   = bif1.bus_EN;
  assign abus[1] = bif1.Async_bus;
  assign busy[1] = bif1.busy;
  assign gid[1]  = bif1.grant_id;

  task automatic check(input int lane, input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL lane%0d %s: got 0x%0h, want 0x%0h (t=%0t)", lane, name, act, exp_v, $time);
    end
  endtask

  for (genvar LN = 0; LN < 2; LN++) begin : g_lane
    localparam int H = (LN == 0) ? 3 : 1;
    localparam int L = (LN == 0) ? 3 : 1;

    // driver: present queue heads, retire a word on its accepting edge
    initial begin : drv
      logic hs0, hs1;
      v0[LN] = 1'b0; v1[LN] = 1'b0; d0[LN] = '0; d1[LN] = '0;
      forever begin
        @(negedge CLK);
        hs0 = (rst_n[LN] === 1'b1) && v0[LN] && (r0[LN] === 1'b1);
        hs1 = (rst_n[LN] === 1'b1) && v1[LN] && (r1[LN] === 1'b1);
        @(posedge CLK);
        #1;
        if (hs0 && src0_q[LN].size() != 0) void'(src0_q[LN].pop_front());
        if (hs1 && src1_q[LN].size() != 0) void'(src1_q[LN].pop_front());
        v0[LN] = (src0_q[LN].size() != 0);
        v1[LN] = (src1_q[LN].size() != 0);
        d0[LN] = '0;
        d1[LN] = '0;
        if (v0[LN]) d0[LN] = src0_q[LN][0];
        if (v1[LN]) d1[LN] = src1_q[LN][0];
      end
    end

    // reference model: a word is taken whenever the block has been free for
    // a whole word period; the grant rotates away from the previous winner
    initial begin : model
      logic last, pick, e0, e1;
      logic [W-1:0] pd;
      m_free[LN] = 0; m_acc[LN] = -1; last = 1'b1;
      forever begin
        @(negedge CLK);
        if (rst_n[LN] !== 1'b1) begin
          m_free[LN] = 0; m_acc[LN] = -1; last = 1'b1;
          exp_q[LN].delete();
        end else begin
          e0 = 1'b0; e1 = 1'b0;
          if (cyc >= m_free[LN] && (v0[LN] || v1[LN])) begin
            pick = ~last;
            if (pick ? !v1[LN] : !v0[LN]) pick = ~pick;
            pd = pick ? d1[LN] : d0[LN];
            if (pick) e1 = 1'b1; else e0 = 1'b1;
            exp_q[LN].push_back({16'(cyc + 1), pick, pd});
            m_acc[LN]  = cyc;
            m_free[LN] = cyc + H + L + 1;
            last = pick;
          end
          check(LN, "req0_ready", 32'(r0[LN]), 32'(e0));
          check(LN, "req1_ready", 32'(r1[LN]), 32'(e1));
          check(LN, "busy", 32'(busy[LN]), 32'(cyc > m_acc[LN] && cyc < m_free[LN]));
        end
      end
    end

    // monitor: every bus_EN rising edge consumes one expected word
    initial begin : mon
      logic en_prev, cur_id, seen;
      logic [W-1:0] cur_bus;
      logic [EW-1:0] e;
      int hi_len, lo_len;
      en_prev = 0; cur_id = 0; seen = 0; cur_bus = '0; hi_len = 0; lo_len = 0;
      pulses[LN] = 0;
      forever begin
        @(negedge CLK);
        if (rst_n[LN] !== 1'b1) begin
          en_prev = 0; cur_id = 0; seen = 0; cur_bus = '0; hi_len = 0; lo_len = 0;
        end else begin
          if (en[LN] === 1'b1 && !en_prev) begin
            pulses[LN]++;
            if (exp_q[LN].size() == 0) begin
              checks++; failures++;
              $display("FAIL lane%0d unexpected_pulse: got bus 0x%0h, want no pulse", LN, abus[LN]);
            end else begin
              e = exp_q[LN].pop_front();
              cur_bus = e[W-1:0];
              cur_id  = e[W];
              check(LN, "rise_cycle", 32'(16'(cyc)), 32'(e[EW-1:W+1]));
              if (seen) check(LN, "gap_len_ok", 32'(lo_len >= L + 1), 32'd1);
              if (LN == 0) dst_q[LN].push_back(cur_bus);
            end
            hi_len = 0;
            seen = 1;
          end
          if (en[LN] !== 1'b1 && en_prev) check(LN, "high_len", 32'(hi_len), 32'(H));
          if (en[LN] === 1'b1) begin
            hi_len++; lo_len = 0;
          end else begin
            lo_len++;
          end
          check(LN, "bus_hold", 32'(abus[LN]), 32'(cur_bus));
          check(LN, "grant_id", 32'(gid[LN]), 32'(cur_id));
          en_prev = (en[LN] === 1'b1);
        end
      end
    end

    // destination: 2-stage synchronizer plus rising-edge pulse in DCLK domain
    if (LN == 0) begin : g_dst
      initial begin : dst
        logic s1, s2, s3;
        s1 = 0; s2 = 0; s3 = 0; dpulses[LN] = 0; dlost[LN] = 0;
        forever begin
          @(posedge DCLK);
          if (rst_n[LN] !== 1'b1) begin
            s1 = 0; s2 = 0; s3 = 0;
            dlost[LN] += dst_q[LN].size();
            dst_q[LN].delete();
          end else begin
            s3 = s2; s2 = s1; s1 = (en[LN] === 1'b1);
            if (s2 && !s3) begin
              dpulses[LN]++;
              if (dst_q[LN].size() == 0) begin
                checks++; failures++;
                $display("FAIL lane%0d dst_extra_pulse: got word 0x%0h, want none", LN, abus[LN]);
              end else begin
                check(LN, "dst_word", 32'(abus[LN]), 32'(dst_q[LN].pop_front()));
              end
            end
          end
        end
      end
    end
  end

  // wait until lane 0 has no pending work and has sat in IDLE
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(src0_q[0].size() == 0 && src1_q[0].size() == 0 && !v0[0] && !v1[0]
             && cyc > m_free[0]) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL lane0 drain_timeout: got %0d cycles, want < %0d", n, budget);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #12;
    for (int l = 0; l < 2; l++) begin
      check(l, "rst_Async_bus", 32'(abus[l]), 32'd0);
      check(l, "rst_bus_EN", 32'(en[l]), 32'd0);
      check(l, "rst_busy", 32'(busy[l]), 32'd0);
      check(l, "rst_grant_id", 32'(gid[l]), 32'd0);
    end
    check(0, "rst_ready0", 32'(r0[0]), 32'd0);
    check(0, "rst_ready1", 32'(r1[0]), 32'd0);
    @(posedge CLK);
    #3;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // lane 1: continuous req0 stream at minimum timing
    for (int i = 0; i < 12; i++) src0_q[1].push_back(W'($urandom));

    // tie from reset: req0 first, then alternate
    src0_q[0].push_back(8'h11); src0_q[0].push_back(8'h11);
    src1_q[0].push_back(8'h22); src1_q[0].push_back(8'h22);
    wait_drain(200);

    // single word
    src0_q[0].push_back(8'hA5);
    wait_drain(100);

    // req1-only streaming
    for (int i = 0; i < 5; i++) src1_q[0].push_back(W'(i));
    wait_drain(200);

    // req1 valid pulsed for one cycle while busy
    src0_q[0].push_back(W'($urandom));
    repeat (3) @(posedge CLK);
    #2;
    v1[0] = 1'b1;
    d1[0] = 8'hEE;
    wait_drain(100);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: src0_q[0].push_back(W'($urandom));
        1: src1_q[0].push_back(W'($urandom));
        2: begin
          src0_q[0].push_back(W'($urandom));
          src1_q[0].push_back(W'($urandom));
        end
        default: ;
      endcase
      repeat ($urandom_range(0, 8)) @(posedge CLK);
      #2;
    end
    wait_drain(1200);

    // reset on the second HIGH cycle
    src0_q[0].push_back(8'h5A);
    n = 0;
    while (en[0] !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check(0, "wait_bus_EN", 32'(en[0]), 32'd1);
    @(posedge CLK);
    #3;
    rst_n[0] = 1'b0;
    #1;
    check(0, "async_rst_bus_EN", 32'(en[0]), 32'd0);
    check(0, "async_rst_busy", 32'(busy[0]), 32'd0);
    check(0, "async_rst_Async_bus", 32'(abus[0]), 32'd0);
    check(0, "async_rst_grant_id", 32'(gid[0]), 32'd0);
    src0_q[0].push_back(8'h61);
    src1_q[0].push_back(8'h72);
    repeat (2) @(posedge CLK);
    #3;
    rst_n[0] = 1'b1;
    wait_drain(100);
    repeat (10) @(posedge CLK);

    for (int l = 0; l < 2; l++) begin
      check(l, "exp_q_empty", 32'(exp_q[l].size()), 32'd0);
      check(l, "src_q_empty", 32'(src0_q[l].size() + src1_q[l].size()), 32'd0);
    end
    check(0, "dst_pulse_count", 32'(dpulses[0]), 32'(pulses[0] - dlost[0]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
